// File: rtl/pe_psum_accumulator_pkg.sv
// pe_acc_pkg: shared sizing defaults, FSM state encoding and saturation
// limits for the PE partial-sum accumulator.
//   NUM_PE  PE lanes
//   PROD_W  signed product width per lane
//   ACC_W   signed accumulator width per lane
//   CNT_W   beat / tile counter width
package pe_acc_pkg;

  localparam int NUM_PE = 16;
  localparam int PROD_W = 32;
  localparam int ACC_W  = 40;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC  = 2'b01,
    HOLD = 2'b10
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/pe_psum_accumulator_sat_add.sv
// psum_sat_add: one accumulator lane. Sign-extends both operands to ACC_W+1
// bits, adds, and clamps the result to the signed ACC_W range.
// Ports:
//   acc   in   ACC_W   current accumulator value (signed)
//   prod  in   PROD_W  product to add (signed)
//   sum   out  ACC_W   saturated acc + prod
module psum_sat_add #(
  parameter int PROD_W = pe_acc_pkg::PROD_W,
  parameter int ACC_W  = pe_acc_pkg::ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum
);

  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] acc_ext_s;
  logic [ACC_W:0] prod_ext_s;
  logic [ACC_W:0] wide_s;

  assign acc_ext_s  = {acc[ACC_W-1], acc};
  assign prod_ext_s = {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
  assign wide_s     = acc_ext_s + prod_ext_s;

  // Clamp: the widened sum overflowed ACC_W when its two top bits disagree;
  // the extra top bit then carries the true sign.
  always_comb begin
    if (wide_s[ACC_W] != wide_s[ACC_W-1]) begin
      if (wide_s[ACC_W]) begin
        sum = SAT_MIN;
      end else begin
        sum = SAT_MAX;
      end
    end else begin
      sum = wide_s[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/pe_psum_accumulator.sv
// pe_psum_accumulator: accumulates per-PE products over a reduction window of
// len beats, then moves the finished partial-sum vector into a one-entry
// shadow register drained through out_valid/out_ready. While the shadow is
// occupied the next tile keeps accumulating; if that tile also finishes before
// the shadow drains the block parks in HOLD and stalls the producer.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           pulse, loads cfg and begins a run (IDLE only)
//   cfg_reduce_len  beats per tile (0 acts as 1)
//   cfg_num_tiles   tiles per run (0 acts as 1)
//   prod_valid/prod product beat, lane i at [i*PROD_W +: PROD_W]
//   acc_stall       producer must hold its beat while high
//   out_valid/out_ready/out_data  shadow handshake, lane i at [i*ACC_W +: ACC_W]
//   tile_done_flag  one-cycle pulse when a tile enters the shadow
//   busy            run in progress or shadow still full
module pe_psum_accumulator
  import pe_acc_pkg::*;
#(
  parameter int NUM_PE = 16,
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         cfg_reduce_len,
  input  logic [CNT_W-1:0]         cfg_num_tiles,
  input  logic                     prod_valid,
  input  logic [NUM_PE*PROD_W-1:0] prod,
  output logic                     acc_stall,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_PE*ACC_W-1:0]  out_data,
  output logic                     tile_done_flag,
  output logic                     busy
);

  localparam logic [CNT_W-1:0]        CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]        CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NUM_PE*ACC_W-1:0] VEC_ZERO = {(NUM_PE*ACC_W){1'b0}};

  state_t                    state_r, state_s;
  logic [CNT_W-1:0]          len_r, len_s;
  logic [CNT_W-1:0]          ntiles_r, ntiles_s;
  logic [CNT_W-1:0]          beat_cnt_r, beat_cnt_s;
  logic [CNT_W-1:0]          tile_cnt_r, tile_cnt_s;
  logic [NUM_PE*ACC_W-1:0]   acc_r, acc_s;
  logic [NUM_PE*ACC_W-1:0]   shadow_r, shadow_s;
  logic [NUM_PE*ACC_W-1:0]   sum_s;
  logic                      out_valid_r, out_valid_s;
  logic                      tile_done_r, tile_done_s;
  logic                      acc_stall_r;
  logic                      busy_r;
  logic                      beat_ok_s;
  logic                      last_beat_s;
  logic                      last_tile_s;
  logic                      shadow_free_s;

  for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
    psum_sat_add #(
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W)
    ) u_sat_add (
      .acc  (acc_r[i*ACC_W +: ACC_W]),
      .prod (prod[i*PROD_W +: PROD_W]),
      .sum  (sum_s[i*ACC_W +: ACC_W])
    );
  end

  assign beat_ok_s     = prod_valid & ~acc_stall_r;
  assign last_beat_s   = (beat_cnt_r == (len_r - CNT_ONE));
  assign last_tile_s   = (tile_cnt_r == (ntiles_r - CNT_ONE));
  // The shadow can take a new tile if empty or being drained this very cycle.
  assign shadow_free_s = ~out_valid_r | out_ready;

  // Next-state, counter, accumulator and shadow computation.
  always_comb begin
    state_s     = state_r;
    len_s       = len_r;
    ntiles_s    = ntiles_r;
    beat_cnt_s  = beat_cnt_r;
    tile_cnt_s  = tile_cnt_r;
    acc_s       = acc_r;
    shadow_s    = shadow_r;
    out_valid_s = out_valid_r & ~out_ready;
    tile_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          len_s      = (cfg_reduce_len == CNT_ZERO) ? CNT_ONE : cfg_reduce_len;
          ntiles_s   = (cfg_num_tiles == CNT_ZERO) ? CNT_ONE : cfg_num_tiles;
          acc_s      = VEC_ZERO;
          beat_cnt_s = CNT_ZERO;
          tile_cnt_s = CNT_ZERO;
          state_s    = ACC;
        end else begin
          state_s = IDLE;
        end
      end
      ACC: begin
        if (beat_ok_s) begin
          if (!last_beat_s) begin
            acc_s      = sum_s;
            beat_cnt_s = beat_cnt_r + CNT_ONE;
          end else if (shadow_free_s) begin
            shadow_s    = sum_s;
            out_valid_s = 1'b1;
            acc_s       = VEC_ZERO;
            beat_cnt_s  = CNT_ZERO;
            tile_done_s = 1'b1;
            // The tile counter stops at ntiles-1 on the final tile.
            if (last_tile_s) begin
              state_s = IDLE;
            end else begin
              tile_cnt_s = tile_cnt_r + CNT_ONE;
            end
          end else begin
            // Finished tile parks in the accumulators until the shadow frees.
            acc_s      = sum_s;
            beat_cnt_s = CNT_ZERO;
            state_s    = HOLD;
          end
        end else begin
          state_s = ACC;
        end
      end
      HOLD: begin
        if (shadow_free_s) begin
          shadow_s    = acc_r;
          out_valid_s = 1'b1;
          acc_s       = VEC_ZERO;
          tile_done_s = 1'b1;
          if (last_tile_s) begin
            state_s = IDLE;
          end else begin
            tile_cnt_s = tile_cnt_r + CNT_ONE;
            state_s    = ACC;
          end
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State registers; status outputs are registered from next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      len_r       <= CNT_ZERO;
      ntiles_r    <= CNT_ZERO;
      beat_cnt_r  <= CNT_ZERO;
      tile_cnt_r  <= CNT_ZERO;
      acc_r       <= VEC_ZERO;
      shadow_r    <= VEC_ZERO;
      out_valid_r <= 1'b0;
      tile_done_r <= 1'b0;
      acc_stall_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      len_r       <= len_s;
      ntiles_r    <= ntiles_s;
      beat_cnt_r  <= beat_cnt_s;
      tile_cnt_r  <= tile_cnt_s;
      acc_r       <= acc_s;
      shadow_r    <= shadow_s;
      out_valid_r <= out_valid_s;
      tile_done_r <= tile_done_s;
      acc_stall_r <= (state_s == HOLD);
      busy_r      <= (state_s != IDLE) | out_valid_s;
    end
  end

  assign acc_stall      = acc_stall_r;
  assign out_valid      = out_valid_r;
  assign out_data       = shadow_r;
  assign tile_done_flag = tile_done_r;
  assign busy           = busy_r;

endmodule
